switch_debounce_reader: RTL
===========================

Name: switch_debounce_reader

Overview:
- Parametrised successor to the board switch reader.
- Synchronises and debounces SWITCH_WIDTH raw FPGA switch lines.
- Exposes the stable switch values and sticky per-bit change flags to the CPU through a 4-word address window, with a registered read.
- Sits between the board switch pins and the memory/IO decoder, and raises an interrupt-style flag when any switch changes state.

Parameters:
- SWITCH_WIDTH, 24, number of raw switch inputs. Range is READ_WIDTH+1 .. 2*READ_WIDTH.
- READ_WIDTH, 16, CPU read data width.
- DEBOUNCE_CYCLES, 4, consecutive clocks a synchronised bit must differ from its stable value before the stable value updates. Minimum 1.

Ports:
- iCpuClock  input  1  the only clock; all state updates on its rising edge.
- iCpuReset  input  1  synchronous, active-high reset.
- iDoSwitchRead  input  1  read strobe from the memory/IO decoder.
- iSwitchAddress  input  2  word select within the switch window.
- iFpgaSwitches  input  SWITCH_WIDTH  raw, asynchronous switch pins.
- oSwitchDataRead  output  READ_WIDTH  registered read data.
- oReadValid  output  1  one-cycle pulse; oSwitchDataRead was updated at the last edge.
- oStableSwitches  output  SWITCH_WIDTH  debounced switch values.
- oChangeIrq  output  1  OR of all change flags.

Behaviour:
- Reset (synchronous, wins over everything): sync stages, stable register, debounce counters, change flags, oSwitchDataRead and oReadValid all go to 0. A reset asserted mid-debounce discards the count.
- Synchroniser: two flip-flop stages per bit (sync1, sync2). No logic between the stages.
- Debounce: one counter per bit, width $clog2(DEBOUNCE_CYCLES+1). At each edge:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Otherwise: counter <= counter+1.
- Debounce timing:
  - A clean input change meeting setup before edge k is visible on oStableSwitches after edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches stable.
- Change flags:
  - flag[i] is set at the same edge that stable[i] changes, in either direction.
  - Flags are sticky until cleared by a read.
  - oChangeIrq = |flags, driven directly from the flag register (no extra delay).
- Address map (read data zero-extended to READ_WIDTH):
  - 2'b00: stable[READ_WIDTH-1:0].
  - 2'b01: stable[SWITCH_WIDTH-1:READ_WIDTH].
  - 2'b10: flags[READ_WIDTH-1:0]; clear-on-read.
  - 2'b11: flags[SWITCH_WIDTH-1:READ_WIDTH]; clear-on-read.
- Read timing:
  - iDoSwitchRead sampled at edge e: oSwitchDataRead loads the selected word at e and oReadValid = 1 for the following cycle.
  - Without a read, oSwitchDataRead holds its value and oReadValid = 0.
  - Back-to-back reads are allowed, one per cycle.
- Clear-on-read:
  - Reads of 2'b10/2'b11 return the pre-edge flag values and clear exactly the returned bits at the same edge.
  - Simultaneous set and clear of the same bit: set wins, flag stays 1. The read returns the old value, so the new event is not lost.
  - Reads of 2'b00/2'b01 never modify the flags.
- After reset, switches already high debounce from 0 to 1 and set their flags. Software clears these with an initial flag read.

Test Plan:
- Reset with iFpgaSwitches=24'h00A5F0 held, DEBOUNCE_CYCLES=4 → oStableSwitches=0 until 6 edges after reset release, then 24'h00A5F0. oChangeIrq rises at that edge.
- Raw bit 3 toggles high for 3 clocks, then returns low → stable bit 3 never changes; flag stays 0; oChangeIrq stays 0.
- iFpgaSwitches=24'hAB1234 stable, read addr 0, then read addr 1 → oSwitchDataRead=16'h1234, then 16'h00AB, each with a single oReadValid pulse one cycle after the strobe.
- Stable bit 17 changes, then read addr 3 twice → first read returns 16'h0002, second returns 16'h0000; oChangeIrq falls after the first read.
- Read addr 2 at the same edge stable bit 0 flips → read returns the old flags (bit 0 = 0); flag[0] = 1 afterwards; oChangeIrq stays high.
- Assert iCpuReset with a read strobe and a debounce in progress → all outputs 0 at the next edge; no oReadValid pulse; the count restarts from 0 after release.

Source files
------------

// File: rtl/switch_debounce_reader_if.sv
// switch_debounce_reader_if: CPU read port of the switch window (strobe, word select, registered data, valid pulse).
interface switch_debounce_reader_if #(
    parameter int READ_WIDTH = 16
);
    logic                  iDoSwitchRead;
    logic [1:0]            iSwitchAddress;
    logic [READ_WIDTH-1:0] oSwitchDataRead;
    logic                  oReadValid;

    modport master (
        output iDoSwitchRead, iSwitchAddress,
        input  oSwitchDataRead, oReadValid
    );

    modport slave (
        input  iDoSwitchRead, iSwitchAddress,
        output oSwitchDataRead, oReadValid
    );
endinterface

// File: rtl/switch_debounce_reader.sv
// switch_debounce_reader: synchronises and debounces board switches, exposing values and sticky change flags to the CPU.
module switch_debounce_reader #(
    parameter int SWITCH_WIDTH    = 24,
    parameter int READ_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    iCpuClock,
    input  logic                    iCpuReset,
    switch_debounce_reader_if.slave cpuBus,
    input  logic [SWITCH_WIDTH-1:0] iFpgaSwitches,
    output logic [SWITCH_WIDTH-1:0] oStableSwitches,
    output logic                    oChangeIrq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = SWITCH_WIDTH - READ_WIDTH;
    localparam logic [SWITCH_WIDTH-1:0] LOW_MASK = {{HW{1'b0}}, {READ_WIDTH{1'b1}}};
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SWITCH_WIDTH-1:0] sync1, sync2, stable, flags, differ, fire, clearMask;
    logic [CW-1:0]           count [SWITCH_WIDTH];
    logic [READ_WIDTH-1:0]   readWord;

    always_comb begin
        differ = sync2 ^ stable;
        fire = '0;
        for (int i = 0; i < SWITCH_WIDTH; i++) fire[i] = differ[i] && count[i] == LAST;
        readWord = !cpuBus.iSwitchAddress[1]
            ? (cpuBus.iSwitchAddress[0] ? READ_WIDTH'(stable[SWITCH_WIDTH-1:READ_WIDTH]) : stable[READ_WIDTH-1:0])
            : (cpuBus.iSwitchAddress[0] ? READ_WIDTH'(flags[SWITCH_WIDTH-1:READ_WIDTH]) : flags[READ_WIDTH-1:0]);
        // a flag read clears only the half it returned; a same-edge set still wins below
        clearMask = (cpuBus.iDoSwitchRead && cpuBus.iSwitchAddress[1])
            ? (cpuBus.iSwitchAddress[0] ? ~LOW_MASK : LOW_MASK) : '0;
    end

    always_ff @(posedge iCpuClock) begin
        if (iCpuReset) begin
            sync1 <= '0;
            sync2 <= '0;
            stable <= '0;
            flags <= '0;
            cpuBus.oSwitchDataRead <= '0;
            cpuBus.oReadValid <= 1'b0;
            for (int i = 0; i < SWITCH_WIDTH; i++) count[i] <= '0;
        end else begin
            sync1 <= iFpgaSwitches;
            sync2 <= sync1;
            stable <= stable ^ fire;
            flags <= (flags & ~clearMask) | fire;
            cpuBus.oReadValid <= cpuBus.iDoSwitchRead;
            if (cpuBus.iDoSwitchRead) cpuBus.oSwitchDataRead <= readWord;
            for (int i = 0; i < SWITCH_WIDTH; i++) count[i] <= (differ[i] && !fire[i]) ? count[i] + CW'(1) : '0;
        end
    end

    assign oStableSwitches = stable;
    assign oChangeIrq = |flags;
endmodule
